// File: rtl/a51_keystream_gen_pkg.sv
// Shared constants, state encoding and helpers for the A5/1 keystream block.
package a51_pkg;

    localparam int R1_LEN = 19;
    localparam int R2_LEN = 22;
    localparam int R3_LEN = 23;

    localparam logic [R1_LEN-1:0] R1_TAPS = 19'h72000;   // bits 13,16,17,18
    localparam logic [R2_LEN-1:0] R2_TAPS = 22'h300000;  // bits 20,21
    localparam logic [R3_LEN-1:0] R3_TAPS = 23'h700080;  // bits 7,20,21,22

    localparam int R1_CLK = 8;
    localparam int R2_CLK = 10;
    localparam int R3_CLK = 10;

    localparam int KEY_BITS   = 64;
    localparam int FRAME_BITS = 22;
    localparam int KF_BITS    = KEY_BITS + FRAME_BITS;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_FRAME,
        MIX,
        STREAM,
        DONE
    } a51_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/a51_keystream_gen_if.sv
// Request/stream bundle between the keyframe source, this block and the XOR stage.
interface a51_keystream_gen_if;
    import a51_pkg::*;

    logic               start;
    logic [KF_BITS-1:0] keyframe;
    logic               ks_ready;
    logic               ks_valid;
    logic               ks_bit;
    logic               busy;
    logic               done;

    modport master (
        output start, keyframe, ks_ready,
        input  ks_valid, ks_bit, busy, done
    );

    modport slave (
        input  start, keyframe, ks_ready,
        output ks_valid, ks_bit, busy, done
    );

endinterface

// File: rtl/a51_lfsr.sv
// One A5/1 shift register: shift left, new bit0 = tap parity ^ in_bit.
module a51_lfsr #(
    parameter int             LEN     = 19,
    parameter logic [LEN-1:0] TAPS    = '0,
    parameter int             CLK_BIT = 0
) (
    input  logic clk,
    input  logic clrn,
    input  logic step,
    input  logic clear,
    input  logic in_bit,
    output logic msb,
    output logic clk_bit
);

    logic [LEN-1:0] r;

    // Register update: clear has priority so a new run always starts from zero.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            r <= '0;
        else if (clear)
            r <= '0;
        else if (step)
            r <= {r[LEN-2:0], (^(r & TAPS)) ^ in_bit};
    end

    assign msb     = r[LEN-1];
    assign clk_bit = r[CLK_BIT];

endmodule

// File: rtl/a51_keystream_gen.sv
// A5/1 key setup and keystream streamer: load key, load frame, mix, then
// hand out KS_LEN bits over a valid/ready handshake.
module a51_keystream_gen
    import a51_pkg::*;
#(
    parameter int KS_LEN     = 228,
    parameter int MIX_CYCLES = 100
) (
    input  logic                clk,
    input  logic                clrn,
    a51_keystream_gen_if.slave  bus
);

    localparam int BCW = $clog2(KS_LEN + 1);

    a51_state_t          state, state_nxt;
    logic [6:0]          setup_cnt, setup_cnt_nxt;
    logic [BCW-1:0]      bit_cnt, bit_cnt_nxt;
    logic [KF_BITS-1:0]  shadow;

    logic capture, clear_regs, step_all, maj_step, in_bit;
    logic ks_valid, done;
    logic m1, m2, m3, c1, c2, c3, maj;
    logic en1, en2, en3;

    logic [KEY_BITS-1:0]   key_bits;
    logic [FRAME_BITS-1:0] frame_bits;

    assign key_bits   = shadow[KF_BITS-1:FRAME_BITS];
    assign frame_bits = shadow[FRAME_BITS-1:0];

    // State, counters and the keyframe shadow copy taken when a run starts.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            setup_cnt <= '0;
            bit_cnt   <= '0;
            shadow    <= '0;
        end else begin
            state     <= state_nxt;
            setup_cnt <= setup_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            if (capture)
                shadow <= bus.keyframe;
        end
    end

    // Next-state, counter and register-step control for each phase.
    always_comb begin
        state_nxt     = state;
        setup_cnt_nxt = setup_cnt;
        bit_cnt_nxt   = bit_cnt;
        capture       = 1'b0;
        clear_regs    = 1'b0;
        step_all      = 1'b0;
        maj_step      = 1'b0;
        in_bit        = 1'b0;
        ks_valid      = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    capture       = 1'b1;
                    clear_regs    = 1'b1;
                    setup_cnt_nxt = '0;
                    bit_cnt_nxt   = '0;
                    state_nxt     = LOAD_KEY;
                end
            end
            LOAD_KEY: begin
                step_all = 1'b1;
                in_bit   = key_bits[setup_cnt[5:0]];
                if (setup_cnt == 7'(KEY_BITS - 1)) begin
                    setup_cnt_nxt = '0;
                    state_nxt     = LOAD_FRAME;
                end else begin
                    setup_cnt_nxt = setup_cnt + 7'd1;
                end
            end
            LOAD_FRAME: begin
                step_all = 1'b1;
                in_bit   = frame_bits[setup_cnt[4:0]];
                if (setup_cnt == 7'(FRAME_BITS - 1)) begin
                    setup_cnt_nxt = '0;
                    state_nxt     = MIX;
                end else begin
                    setup_cnt_nxt = setup_cnt + 7'd1;
                end
            end
            MIX: begin
                // MIX_CYCLES+1 steps: the last one pre-clocks the first output bit.
                maj_step = 1'b1;
                if (setup_cnt == 7'(MIX_CYCLES)) begin
                    setup_cnt_nxt = '0;
                    state_nxt     = STREAM;
                end else begin
                    setup_cnt_nxt = setup_cnt + 7'd1;
                end
            end
            STREAM: begin
                ks_valid = 1'b1;
                if (bus.ks_ready) begin
                    maj_step    = 1'b1;
                    bit_cnt_nxt = bit_cnt + BCW'(1);
                    if (bit_cnt == BCW'(KS_LEN - 1))
                        state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign maj = maj3(c1, c2, c3);
    assign en1 = step_all | (maj_step & (c1 == maj));
    assign en2 = step_all | (maj_step & (c2 == maj));
    assign en3 = step_all | (maj_step & (c3 == maj));

    a51_lfsr #(.LEN(R1_LEN), .TAPS(R1_TAPS), .CLK_BIT(R1_CLK)) u_r1 (
        .clk(clk), .clrn(clrn), .step(en1), .clear(clear_regs),
        .in_bit(in_bit), .msb(m1), .clk_bit(c1)
    );

    a51_lfsr #(.LEN(R2_LEN), .TAPS(R2_TAPS), .CLK_BIT(R2_CLK)) u_r2 (
        .clk(clk), .clrn(clrn), .step(en2), .clear(clear_regs),
        .in_bit(in_bit), .msb(m2), .clk_bit(c2)
    );

    a51_lfsr #(.LEN(R3_LEN), .TAPS(R3_TAPS), .CLK_BIT(R3_CLK)) u_r3 (
        .clk(clk), .clrn(clrn), .step(en3), .clear(clear_regs),
        .in_bit(in_bit), .msb(m3), .clk_bit(c3)
    );

    assign bus.ks_valid = ks_valid;
    assign bus.ks_bit   = m1 ^ m2 ^ m3;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done;

endmodule
